mips_multicycle_ctrl: RTL



---
 rtl/mips_ctrl_pkg.sv | 67 ++++++
 rtl/alu_decoder.sv | 36 +++
 rtl/mips_multicycle_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS control unit.
package mips_ctrl_pkg;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct field (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // ALU func codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // pc_src encodings
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // alu_src_b encodings
  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // ALU operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } ctrl_state_t;

  // True for the opcodes this core can execute
  function automatic logic is_supported_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control: maps an operation class plus funct to an ALU code.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_op_t     alu_op_i,
  input  logic [5:0]  funct_i,
  output logic [3:0]  alu_func_o,
  output logic        bad_funct_o
);

  // Unknown funct values fall back to ADD and raise the bad-funct flag
  always_comb begin
    alu_func_o  = ALU_ADD;
    bad_funct_o = 1'b0;
    case (alu_op_i)
      ALUOP_ADD: alu_func_o = ALU_ADD;
      ALUOP_SUB: alu_func_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_func_o = ALU_ADD;
          FN_SUB:  alu_func_o = ALU_SUB;
          FN_AND:  alu_func_o = ALU_AND;
          FN_OR:   alu_func_o = ALU_OR;
          FN_SLT:  alu_func_o = ALU_SLT;
          FN_NOR:  alu_func_o = ALU_NOR;
          default: begin
            alu_func_o  = ALU_ADD;
            bad_funct_o = 1'b1;
          end
        endcase
      end
      default: alu_func_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and drives datapath strobes and mux selects. Outputs are a Moore decode of the
// state, with the memory-handshake strobes and the branch PC load gated by
// mem_ready and z_flag in the same cycle.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             z_flag,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             wr_en,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_func,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  ctrl_state_t      state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  alu_op_t          alu_op;
  logic             alu_active;
  logic [3:0]       dec_func;
  logic             bad_funct;

  alu_decoder u_alu_decoder (
    .alu_op_i    (alu_op),
    .funct_i     (funct),
    .alu_func_o  (dec_func),
    .bad_funct_o (bad_funct)
  );

  // Next state, sticky illegal flag and retired-instruction count
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase

    illegal_d = illegal_q;
    if ((state_q == S_DECODE) && !is_supported_op(opcode)) illegal_d = 1'b1;
    if ((state_q == S_EXEC) && bad_funct)                  illegal_d = 1'b1;

    // An instruction retires whenever the FSM returns to FETCH
    cnt_d = cnt_q;
    if ((state_d == S_FETCH) && (state_q != S_FETCH)) cnt_d = cnt_q + 1'b1;
  end

  // State, counter and sticky flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  // Per-state datapath controls; everything is forced low while in reset
  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PC_SRC_ALU;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    wr_en      = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    alu_active = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRCB_FOUR;
          alu_active = 1'b1;
          ir_we      = mem_ready;
          pc_en      = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMM_SH;
          alu_active = 1'b1;
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          alu_active = 1'b1;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          wr_en      = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = mem_ready;
        end
        S_EXEC: begin
          alu_src_a  = 1'b1;
          alu_op     = ALUOP_FUNCT;
          alu_active = 1'b1;
        end
        S_ALUWB: begin
          wr_en   = 1'b1;
          reg_dst = 1'b1;
        end
        S_ADDIWB: wr_en = 1'b1;
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALUOP_SUB;
          alu_active = 1'b1;
          pc_src     = PC_SRC_ALUOUT;
          pc_en      = z_flag;
        end
        S_JUMP: begin
          pc_src = PC_SRC_JUMP;
          pc_en  = 1'b1;
        end
        default: ;
      endcase
    end
    alu_func = alu_active ? dec_func : 4'b0000;
  end

  assign illegal   = illegal_q;
  assign instr_cnt = cnt_q;

endmodule
